id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/pipe_field.sv | 27 ++
 rtl/id_ex_reg.sv | 147 ++++++++++++++
 tb/tb_id_ex_reg.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: control bundle layouts, bubble constants and
// the small enums used by the ID/EX pipeline register.
package mips_pkg;

    // Control bundle widths
    localparam int CTRL_EX_W = 6;  // {reg_dst, alu_src, alu_op[3:0]}
    localparam int CTRL_M_W  = 3;  // {mem_read, mem_write, branch}
    localparam int CTRL_WB_W = 2;  // {reg_write, mem_to_reg}

    // EX bundle field positions
    localparam int EX_REG_DST    = 5;
    localparam int EX_ALU_SRC    = 4;
    localparam int EX_ALU_OP_MSB = 3;
    localparam int EX_ALU_OP_LSB = 0;

    // MEM bundle field positions
    localparam int M_MEM_READ  = 2;
    localparam int M_MEM_WRITE = 1;
    localparam int M_BRANCH    = 0;

    // WB bundle field positions
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    // Shift amount lives in imm[10:6] of an R-type encoding
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int SHAMT_W   = SHAMT_MSB - SHAMT_LSB + 1;

    // A bubble is a no-op: no register write, no memory access, no branch
    localparam logic [CTRL_EX_W-1:0] CTRL_EX_BUBBLE = '0;
    localparam logic [CTRL_M_W-1:0]  CTRL_M_BUBBLE  = '0;
    localparam logic [CTRL_WB_W-1:0] CTRL_WB_BUBBLE = '0;

    // What every field register does on the coming edge (reset is separate)
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_CLEAR = 2'd2
    } field_act_e;

    // Observability-only indicator: did the last edge hold the contents?
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HELD = 1'b1
    } hold_state_e;

endpackage

// File: rtl/pipe_field.sv
// One pipeline-register field with synchronous reset, clear (bubble), load
// and hold. Reset and clear both drive CLEAR_VAL; reset wins over everything.
module pipe_field #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Field register: reset > clear > load > hold
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (i_reset) begin
            o_q <= CLEAR_VAL;
        end else if (i_clear) begin
            o_q <= CLEAR_VAL;
        end else if (i_load) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Every output except o_shamt comes straight from a
// flop. Edge priority: reset > freeze (!enable) > flush > stall > load, and a
// load of a non-valid instruction becomes a bubble.
module id_ex_reg
    import mips_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int NB_REG     = 5,
    parameter int NB_CTRL_EX = CTRL_EX_W,
    parameter int NB_CTRL_M  = CTRL_M_W,
    parameter int NB_CTRL_WB = CTRL_WB_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [NB_DATA-1:0]    i_pc4,
    input  logic [NB_DATA-1:0]    i_rs_data,
    input  logic [NB_DATA-1:0]    i_rt_data,
    input  logic [NB_DATA-1:0]    i_imm_ext,
    input  logic [NB_REG-1:0]     i_rs,
    input  logic [NB_REG-1:0]     i_rt,
    input  logic [NB_REG-1:0]     i_rd,
    input  logic [NB_CTRL_EX-1:0] i_ctrl_ex,
    input  logic [NB_CTRL_M-1:0]  i_ctrl_m,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb,
    output logic                  o_valid,
    output logic [NB_DATA-1:0]    o_pc4,
    output logic [NB_DATA-1:0]    o_rs_data,
    output logic [NB_DATA-1:0]    o_rt_data,
    output logic [NB_DATA-1:0]    o_imm_ext,
    output logic [NB_REG-1:0]     o_rs,
    output logic [NB_REG-1:0]     o_rt,
    output logic [NB_REG-1:0]     o_rd,
    output logic [NB_CTRL_EX-1:0] o_ctrl_ex,
    output logic [NB_CTRL_M-1:0]  o_ctrl_m,
    output logic [NB_CTRL_WB-1:0] o_ctrl_wb,
    output logic [SHAMT_W-1:0]    o_shamt
);

    field_act_e  act;
    logic        fld_load;
    logic        fld_clear;
    hold_state_e state;
    hold_state_e state_next;

    // Decode the per-edge action shared by every field
    always_comb begin
        // NOTE: default first so every path assigns act and no latch is inferred.
        act = ACT_LOAD;
        if (!i_enable) begin
            act = ACT_HOLD;
        end else if (i_flush) begin
            act = ACT_CLEAR;
        end else if (i_stall) begin
            act = ACT_HOLD;
        end else if (!i_valid) begin
            act = ACT_CLEAR;
        end
        fld_load  = (act == ACT_LOAD);
        fld_clear = (act == ACT_CLEAR);
    end

    // Hold indicator register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Hold indicator next state: HELD exactly when this edge holds contents
    always_comb begin
        state_next = ST_RUN;
        if (act == ACT_HOLD) begin
            state_next = ST_HELD;
        end
    end

    pipe_field #(.WIDTH(1)) u_valid (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(fld_clear), .i_load(fld_load),
        .i_d(i_valid), .o_q(o_valid)
    );

    pipe_field #(.WIDTH(NB_DATA)) u_pc4 (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(fld_clear), .i_load(fld_load),
        .i_d(i_pc4), .o_q(o_pc4)
    );

    pipe_field #(.WIDTH(NB_DATA)) u_rs_data (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(fld_clear), .i_load(fld_load),
        .i_d(i_rs_data), .o_q(o_rs_data)
    );

    pipe_field #(.WIDTH(NB_DATA)) u_rt_data (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(fld_clear), .i_load(fld_load),
        .i_d(i_rt_data), .o_q(o_rt_data)
    );

    pipe_field #(.WIDTH(NB_DATA)) u_imm_ext (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(fld_clear), .i_load(fld_load),
        .i_d(i_imm_ext), .o_q(o_imm_ext)
    );

    pipe_field #(.WIDTH(NB_REG)) u_rs (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(fld_clear), .i_load(fld_load),
        .i_d(i_rs), .o_q(o_rs)
    );

    pipe_field #(.WIDTH(NB_REG)) u_rt (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(fld_clear), .i_load(fld_load),
        .i_d(i_rt), .o_q(o_rt)
    );

    pipe_field #(.WIDTH(NB_REG)) u_rd (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(fld_clear), .i_load(fld_load),
        .i_d(i_rd), .o_q(o_rd)
    );

    pipe_field #(
        .WIDTH(NB_CTRL_EX), .CLEAR_VAL(NB_CTRL_EX'(CTRL_EX_BUBBLE))
    ) u_ctrl_ex (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(fld_clear), .i_load(fld_load),
        .i_d(i_ctrl_ex), .o_q(o_ctrl_ex)
    );

    pipe_field #(
        .WIDTH(NB_CTRL_M), .CLEAR_VAL(NB_CTRL_M'(CTRL_M_BUBBLE))
    ) u_ctrl_m (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(fld_clear), .i_load(fld_load),
        .i_d(i_ctrl_m), .o_q(o_ctrl_m)
    );

    pipe_field #(
        .WIDTH(NB_CTRL_WB), .CLEAR_VAL(NB_CTRL_WB'(CTRL_WB_BUBBLE))
    ) u_ctrl_wb (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(fld_clear), .i_load(fld_load),
        .i_d(i_ctrl_wb), .o_q(o_ctrl_wb)
    );

    // Shift amount is a pure slice of the registered immediate
    assign o_shamt = o_imm_ext[SHAMT_MSB:SHAMT_LSB];

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a reference model computes the expected
// contents per edge, pushes them to a scoreboard queue, and the entry is popped
// and compared one cycle later. Directed spot checks use literal constants.
module tb_id_ex_reg;
    import mips_pkg::*;

    typedef struct packed {
        logic        reset;
        logic        enable;
        logic        stall;
        logic        flush;
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  ex;
        logic [2:0]  m;
        logic [1:0]  wb;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  ex;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic        held;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_reset, i_enable, i_stall, i_flush, i_valid;
    logic [31:0] i_pc4, i_rs_data, i_rt_data, i_imm_ext;
    logic [4:0]  i_rs, i_rt, i_rd;
    logic [5:0]  i_ctrl_ex;
    logic [2:0]  i_ctrl_m;
    logic [1:0]  i_ctrl_wb;
    logic        o_valid;
    logic [31:0] o_pc4, o_rs_data, o_rt_data, o_imm_ext;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [5:0]  o_ctrl_ex;
    logic [2:0]  o_ctrl_m;
    logic [1:0]  o_ctrl_wb;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t model_q  = '0;
    exp_t sb[$];

    always #5 i_clk = ~i_clk;

    id_ex_reg dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
        .i_flush(i_flush), .i_valid(i_valid), .i_pc4(i_pc4), .i_rs_data(i_rs_data),
        .i_rt_data(i_rt_data), .i_imm_ext(i_imm_ext), .i_rs(i_rs), .i_rt(i_rt),
        .i_rd(i_rd), .i_ctrl_ex(i_ctrl_ex), .i_ctrl_m(i_ctrl_m), .i_ctrl_wb(i_ctrl_wb),
        .o_valid(o_valid), .o_pc4(o_pc4), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
        .o_imm_ext(o_imm_ext), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_ctrl_ex(o_ctrl_ex), .o_ctrl_m(o_ctrl_m), .o_ctrl_wb(o_ctrl_wb),
        .o_shamt(o_shamt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Random instruction presented for a plain load
    function automatic in_t rand_in();
        in_t t;
        t.reset   = 1'b0;
        t.enable  = 1'b1;
        t.stall   = 1'b0;
        t.flush   = 1'b0;
        t.valid   = 1'b1;
        t.pc4     = $urandom;
        t.rs_data = $urandom;
        t.rt_data = $urandom;
        t.imm     = $urandom;
        t.rs      = 5'($urandom);
        t.rt      = 5'($urandom);
        t.rd      = 5'($urandom);
        t.ex      = 6'($urandom);
        t.m       = 3'($urandom);
        t.wb      = 2'($urandom);
        return t;
    endfunction

    // Reference behaviour of one rising edge
    function automatic exp_t model(input exp_t cur, input in_t t);
        exp_t n;
        n = cur;
        n.held = 1'b0;
        if (t.reset) begin
            n = '0;
        end else if (!t.enable) begin
            n.held = 1'b1;
        end else if (t.flush) begin
            n = '0;
        end else if (t.stall) begin
            n.held = 1'b1;
        end else if (!t.valid) begin
            n = '0;
        end else begin
            n.valid   = 1'b1;
            n.pc4     = t.pc4;
            n.rs_data = t.rs_data;
            n.rt_data = t.rt_data;
            n.imm     = t.imm;
            n.rs      = t.rs;
            n.rt      = t.rt;
            n.rd      = t.rd;
            n.ex      = t.ex;
            n.m       = t.m;
            n.wb      = t.wb;
        end
        return n;
    endfunction

    // Drive one cycle, queue its expectation, then compare after the edge
    task automatic step(input in_t t);
        exp_t e;
        i_reset   = t.reset;
        i_enable  = t.enable;
        i_stall   = t.stall;
        i_flush   = t.flush;
        i_valid   = t.valid;
        i_pc4     = t.pc4;
        i_rs_data = t.rs_data;
        i_rt_data = t.rt_data;
        i_imm_ext = t.imm;
        i_rs      = t.rs;
        i_rt      = t.rt;
        i_rd      = t.rd;
        i_ctrl_ex = t.ex;
        i_ctrl_m  = t.m;
        i_ctrl_wb = t.wb;
        model_q = model(model_q, t);
        sb.push_back(model_q);
        @(posedge i_clk);
        #1;
        e = sb.pop_front();
        check("valid",   32'(o_valid),   32'(e.valid));
        check("pc4",     o_pc4,          e.pc4);
        check("rs_data", o_rs_data,      e.rs_data);
        check("rt_data", o_rt_data,      e.rt_data);
        check("imm_ext", o_imm_ext,      e.imm);
        check("rs",      32'(o_rs),      32'(e.rs));
        check("rt",      32'(o_rt),      32'(e.rt));
        check("rd",      32'(o_rd),      32'(e.rd));
        check("ctrl_ex", 32'(o_ctrl_ex), 32'(e.ex));
        check("ctrl_m",  32'(o_ctrl_m),  32'(e.m));
        check("ctrl_wb", 32'(o_ctrl_wb), 32'(e.wb));
        check("shamt",   32'(o_shamt),   32'(e.imm[10:6]));
        check("held",    32'(dut.state == ST_HELD), 32'(e.held));
    endtask

    initial begin
        in_t t;
        i_reset = 1'b1; i_enable = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
        i_pc4 = '0; i_rs_data = '0; i_rt_data = '0; i_imm_ext = '0;
        i_rs = '0; i_rt = '0; i_rd = '0; i_ctrl_ex = '0; i_ctrl_m = '0; i_ctrl_wb = '0;
        #2;

        // Reset with busy inputs clears everything
        t = rand_in(); t.reset = 1'b1; step(t);
        check("reset_valid", 32'(o_valid), 32'h0);

        // First load: one-cycle latency
        t = rand_in(); t.imm = 32'h0000_0007; t.rd = 5'd3; t.wb = 2'b10; step(t);
        check("load_imm", o_imm_ext, 32'h0000_0007);
        check("load_rd", 32'(o_rd), 32'd3);
        check("load_wb", 32'(o_ctrl_wb), 32'h2);
        check("load_valid", 32'(o_valid), 32'h1);

        // Negative immediate passes unmodified, then survives a 3-cycle stall
        t = rand_in(); t.imm = 32'hFFFF_FF01; step(t);
        check("neg_imm", o_imm_ext, 32'hFFFF_FF01);
        for (int i = 0; i < 3; i++) begin
            t = rand_in(); t.stall = 1'b1; step(t);
            check("stall_imm", o_imm_ext, 32'hFFFF_FF01);
        end
        t = rand_in(); t.imm = 32'h1234_5678; step(t);
        check("post_stall_imm", o_imm_ext, 32'h1234_5678);

        // Flush of a valid instruction yields a bubble
        t = rand_in(); t.flush = 1'b1; t.m = 3'b011; t.rs_data = 32'hDEAD_BEEF; step(t);
        check("flush_m", 32'(o_ctrl_m), 32'h0);
        check("flush_rs_data", o_rs_data, 32'h0);

        // Freeze dominates flush, then the flush takes effect once enabled
        t = rand_in(); step(t);
        t = rand_in(); t.enable = 1'b0; t.flush = 1'b1; step(t);
        t = rand_in(); t.flush = 1'b1; step(t);

        // Reset during a stall clears a loaded pc4
        t = rand_in(); t.pc4 = 32'h0000_0040; step(t);
        check("pc4_loaded", o_pc4, 32'h0000_0040);
        t = rand_in(); t.stall = 1'b1; t.reset = 1'b1; step(t);
        check("stall_reset_pc4", o_pc4, 32'h0);

        // Shift amount slice
        t = rand_in(); t.imm = 32'h0000_0111; step(t);
        check("shamt_0x111", 32'(o_shamt), 32'h04);

        // Invalid instruction on a load, then flush together with stall
        t = rand_in(); t.valid = 1'b0; step(t);
        t = rand_in(); step(t);
        t = rand_in(); t.flush = 1'b1; t.stall = 1'b1; step(t);

        // Reset during a freeze, then a stall right after deassert
        t = rand_in(); step(t);
        t = rand_in(); t.enable = 1'b0; t.reset = 1'b1; step(t);
        t = rand_in(); t.stall = 1'b1; step(t);

        // Mixed random traffic through the model
        for (int i = 0; i < 40; i++) begin
            t = rand_in();
            t.enable = ($urandom_range(0, 5) != 0);
            t.stall  = ($urandom_range(0, 3) == 0);
            t.flush  = ($urandom_range(0, 5) == 0);
            t.valid  = ($urandom_range(0, 4) != 0);
            t.reset  = ($urandom_range(0, 19) == 0);
            step(t);
        end

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
